// File: rtl/instr_enc_pkg.sv
// Shared opcode numbering, format groups and fixed encodings for the
// instruction stream encoder.
package instr_enc_pkg;

  localparam logic [5:0] OP_JMR  = 6'd0;
  localparam logic [5:0] OP_RSV  = 6'd2;
  localparam logic [5:0] OP_SIM  = 6'd12;
  localparam logic [5:0] OP_SEB  = 6'd13;
  localparam logic [5:0] OP_LOB  = 6'd16;
  localparam logic [5:0] OP_ADD  = 6'd17;
  localparam logic [5:0] OP_COMP = 6'd32;
  localparam logic [5:0] OP_MUL  = 6'd33;
  localparam logic [5:0] OP_MLS  = 6'd34;
  localparam logic [5:0] OP_JMD  = 6'd35;
  localparam logic [5:0] OP_CALL = 6'd36;
  localparam logic [5:0] OP_LDA  = 6'd37;
  localparam logic [5:0] OP_RTN  = 6'd38;
  localparam logic [5:0] OP_CLI  = 6'd54;
  localparam logic [5:0] OP_BRU  = 6'd55;
  localparam logic [5:0] OP_BRD  = 6'd56;

  localparam logic [3:0]  COND_ALWAYS  = 4'b0110;
  localparam logic [3:0]  COND_INVALID = 4'b1110;
  localparam logic [15:0] STP_WORD     = 16'hF016;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  typedef enum logic [2:0] {
    FMT_COND   = 3'd0,
    FMT_BITIMM = 3'd1,
    FMT_DUAL   = 3'd2,
    FMT_TRIPLE = 3'd3,
    FMT_ABS    = 3'd4,
    FMT_SYS    = 3'd5,
    FMT_BRANCH = 3'd6,
    FMT_BAD    = 3'd7
  } fmt_e;

  // Maps an opcode index onto its word layout; holes and out-of-range map to FMT_BAD.
  function automatic fmt_e op_format(input logic [5:0] op);
    fmt_e f;
    if (op == OP_RSV)       f = FMT_BAD;
    else if (op <= OP_SIM)  f = FMT_COND;
    else if (op <= OP_LOB)  f = FMT_BITIMM;
    else if (op <= OP_COMP) f = FMT_DUAL;
    else if (op <= OP_MLS)  f = FMT_TRIPLE;
    else if (op <= OP_LDA)  f = FMT_ABS;
    else if (op <= OP_CLI)  f = FMT_SYS;
    else if (op <= OP_BRD)  f = FMT_BRANCH;
    else                    f = FMT_BAD;
    return f;
  endfunction

endpackage

// File: rtl/instr_format_pack.sv
// Combinational packer: structured instruction fields to one 16-bit word,
// with a flag telling whether the instruction is encodable.
module instr_format_pack
  import instr_enc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [3:0]  cond,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [2:0]  rc,
  input  logic [11:0] imm,
  output logic [15:0] word,
  output logic        valid
);

  fmt_e       fmt_s;
  logic [5:0] rel_s;
  logic       cond_ok_s;

  // Select the layout and pack fields; rel_s is the opcode offset within its group.
  always_comb begin
    fmt_s     = op_format(op);
    cond_ok_s = (cond != COND_INVALID);
    rel_s     = 6'd0;
    word      = 16'h0000;
    valid     = 1'b0;
    case (fmt_s)
      FMT_COND: begin
        word  = {3'b000, op, cond, ra};
        valid = cond_ok_s;
      end
      FMT_BITIMM: begin
        rel_s = op - OP_SEB;
        word  = {5'b00100 + rel_s[4:0], cond, ra, imm[3:0]};
        valid = cond_ok_s;
      end
      FMT_DUAL: begin
        rel_s = op - OP_ADD;
        word  = {6'b010000 + rel_s, cond, ra, rb};
        valid = cond_ok_s;
      end
      FMT_TRIPLE: begin
        rel_s = op - OP_MUL;
        word  = {3'b100 + {2'b00, rel_s[0]}, cond, ra, rc, rb};
        valid = cond_ok_s;
      end
      FMT_ABS: begin
        // Absolute jumps carry no cond field, so the input cond is never checked.
        rel_s = op - OP_JMD;
        word  = {4'b1100 + {2'b00, rel_s[1:0]}, imm};
        valid = 1'b1;
      end
      FMT_SYS: begin
        rel_s = op - OP_RTN;
        word  = {12'hF00 + {6'b000000, rel_s}, cond};
        valid = cond_ok_s;
      end
      FMT_BRANCH: begin
        rel_s = op - OP_BRU;
        word  = {8'b11111000, rel_s[0], cond, imm[2:0]};
        valid = cond_ok_s;
      end
      default: begin
        word  = 16'h0000;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Load-session controller: packs accepted instructions and writes them to
// consecutive instruction-RAM addresses, closing each session with STP.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [3:0]        cond,
  input  logic [2:0]        ra,
  input  logic [2:0]        rb,
  input  logic [2:0]        rc,
  input  logic [11:0]       imm,
  input  logic              finish,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The final slot is held back so STP always fits.
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  enc_state_e        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [15:0]       wr_data_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [15:0]       pack_word_s;
  logic              pack_valid_s;
  logic              xfer_s;

  instr_format_pack u_pack (
    .op    (op),
    .cond  (cond),
    .ra    (ra),
    .rb    (rb),
    .rc    (rc),
    .imm   (imm),
    .word  (pack_word_s),
    .valid (pack_valid_s)
  );

  // FLUSH doubles as the finish-pending condition, so LOAD alone admits input.
  assign in_ready = (state_r == ST_LOAD) && (count_r < LAST_SLOT);
  assign xfer_s   = in_valid && in_ready;

  // Session FSM with the write port, pointer, counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      ptr_r     <= '0;
      count_r   <= '0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 16'h0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_LOAD;
            ptr_r   <= base_addr;
            count_r <= '0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            if (pack_valid_s) begin
              wr_en_r   <= 1'b1;
              wr_addr_r <= ptr_r;
              wr_data_r <= pack_word_s;
              ptr_r     <= ptr_r + ADDR_W'(1);
              count_r   <= count_r + (ADDR_W+1)'(1);
            end else begin
              err_r <= 1'b1;
            end
          end
          if (finish) begin
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= ptr_r;
          wr_data_r <= STP_WORD;
          ptr_r     <= ptr_r + ADDR_W'(1);
          count_r   <= count_r + (ADDR_W+1)'(1);
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign count   = count_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed scoreboard bench for instr_stream_encoder (ADDR_W=8, DEPTH=4).
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op = 6'd0;
  logic [3:0]  cond = 4'd0;
  logic [2:0]  ra = 3'd0;
  logic [2:0]  rb = 3'd0;
  logic [2:0]  rc = 3'd0;
  logic [11:0] imm = 12'h000;
  logic        finish = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [8:0]  count;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  instr_stream_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .cond(cond),
    .ra(ra), .rb(rb), .rc(rc), .imm(imm), .finish(finish),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, wr_en}, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[23:16]});
        chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
      end
    end
  end

  task automatic do_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] o, input logic [3:0] c, input logic [2:0] a,
                      input logic [2:0] b, input logic [2:0] cc, input logic [11:0] im);
    op = o; cond = c; ra = a; rb = b; rc = cc; imm = im;
    in_valid = 1'b1;
    chk("in_ready_at_send", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_finish(input logic [7:0] stp_addr, input logic [8:0] exp_cnt);
    in_valid = 1'b0;
    finish = 1'b1;
    push(stp_addr, 16'hF016);
    @(posedge clk); #1;
    finish = 1'b0;
    @(posedge clk); #1;
    chk("done_after_stp", {31'd0, done}, 32'd1);
    chk("busy_after_stp", {31'd0, busy}, 32'd0);
    chk("count_after_stp", {23'd0, count}, {23'd0, exp_cnt});
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single add
    do_start(8'h10);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    push(8'h10, 16'h4195);
    send(6'd17, 4'b0110, 3'd2, 3'd5, 3'd0, 12'h000);
    in_valid = 1'b0;
    chk("add_count", {23'd0, count}, 32'd1);
    do_finish(8'h11, 9'd2);

    // Back-to-back mul then call
    do_start(8'h10);
    chk("done_cleared_by_start", {31'd0, done}, 32'd0);
    push(8'h10, 16'h8C5C);
    send(6'd33, 4'b0110, 3'd1, 3'd4, 3'd3, 12'h000);
    push(8'h11, 16'hDABC);
    send(6'd36, 4'b0110, 3'd0, 3'd0, 3'd0, 12'hABC);
    in_valid = 1'b0;
    chk("b2b_count", {23'd0, count}, 32'd2);
    do_finish(8'h12, 9'd3);

    // Invalid instructions: reserved op 2, then cond 1110
    do_start(8'h20);
    send(6'd2, 4'b0110, 3'd1, 3'd0, 3'd0, 12'h000);
    send(6'd5, 4'b1110, 3'd1, 3'd0, 3'd0, 12'h000);
    in_valid = 1'b0;
    chk("inv_err", {31'd0, err}, 32'd1);
    chk("inv_count", {23'd0, count}, 32'd0);
    push(8'h20, 16'hF006);
    send(6'd38, 4'b0110, 3'd0, 3'd0, 3'd0, 12'h000);
    send(6'd57, 4'b0110, 3'd0, 3'd0, 3'd0, 12'h000);
    in_valid = 1'b0;
    chk("inv_err_sticky", {31'd0, err}, 32'd1);
    chk("inv_count_after_valid", {23'd0, count}, 32'd1);
    do_finish(8'h21, 9'd2);

    // Fill to the reserved slot, address wrap, start ignored mid-session
    do_start(8'hFE);
    chk("err_cleared_by_start", {31'd0, err}, 32'd0);
    push(8'hFE, 16'h0007);
    send(6'd0, 4'b0000, 3'd7, 3'd0, 3'd0, 12'h000);
    start = 1'b1;
    base_addr = 8'h80;
    push(8'hFF, 16'h2335);
    send(6'd13, 4'b0110, 3'd3, 3'd0, 3'd0, 12'hFA5);
    start = 1'b0;
    push(8'h00, 16'hC123);
    send(6'd35, 4'b1110, 3'd0, 3'd0, 3'd0, 12'h123);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {23'd0, count}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_count_hold", {23'd0, count}, 32'd3);
    do_finish(8'h01, 9'd4);

    // finish together with a transfer
    do_start(8'h40);
    push(8'h40, 16'hF835);
    push(8'h41, 16'hF016);
    op = 6'd55; cond = 4'b0110; ra = 3'd0; rb = 3'd0; rc = 3'd0; imm = 12'h005;
    in_valid = 1'b1;
    finish = 1'b1;
    chk("in_ready_bru", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish = 1'b0;
    chk("bru_wr_en", {31'd0, wr_en}, 32'd1);
    chk("bru_count", {23'd0, count}, 32'd1);
    @(posedge clk); #1;
    chk("bru_stp_done", {31'd0, done}, 32'd1);
    chk("bru_stp_count", {23'd0, count}, 32'd2);

    // Reset during LOAD with a write on the port
    do_start(8'h50);
    send(6'd17, 4'b0110, 3'd2, 3'd5, 3'd0, 12'h000);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_count", {23'd0, count}, 32'd0);
    chk("midrst_flags", {28'd0, busy, done, err, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd0);
    do_start(8'h60);
    chk("postrst_start_ready", {31'd0, in_ready}, 32'd1);

    repeat (2) @(posedge clk);
    #1;
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
